// File: rtl/secret_driver.sv
// Stimulus/response checker for the protected secret accumulator: drives LFSR operands,
// mirrors the accumulator in a cycle-accurate model and counts mismatches.
// Optional feature: define SECRET_DRIVER_GATED_CLK_EN to drive a randomised clk_en.
module secret_driver #(
  parameter logic [31:0] SECRET_VALUE = 32'd7,
  parameter int unsigned NUM_CYCLES   = 256,
  parameter logic [31:0] LFSR_TAPS    = 32'h8020_0003
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] seed,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] err_count,
  output logic [15:0] first_err_cycle,
  output logic [31:0] accum_in,
  output logic        accum_bypass,
  output logic        clk_en,
  input  logic [31:0] accum_out,
  input  logic [31:0] accum_bypass_out
);

  typedef enum logic [1:0] {StIdle, StSync, StRun, StDone} state_e;

  localparam logic [15:0] LastCycle = 16'(NUM_CYCLES - 1);
  localparam logic [15:0] NoErr     = 16'hFFFF;

  state_e      state_q, state_d;
  logic [31:0] lfsr_q, lfsr_d, lfsr_step;
  logic [31:0] model_q, model_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] err_q, err_d;
  logic [15:0] first_q, first_d;
  logic        pass_q, pass_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [31:0] accum_in_q, accum_in_d;
  logic        bypass_q, bypass_d;
  logic        eff_en;
  logic        mismatch;

`ifdef SECRET_DRIVER_GATED_CLK_EN
  logic clk_en_q, clk_en_d;
  // The accumulator latches clk_en while clk is low, so the value on the port now is the
  // enable it applies at the coming edge.
  assign eff_en = clk_en_q;
  assign clk_en = clk_en_q;
`else
  assign eff_en = 1'b1;
  assign clk_en = 1'b1;
`endif

  assign lfsr_step = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 32'h0);
  assign mismatch  = (accum_out != model_q) ||
                     (accum_bypass_out != (bypass_q ? accum_in_q : model_q));

  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    model_d    = model_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    first_d    = first_q;
    pass_d     = pass_q;
    accum_in_d = accum_in_q;
    bypass_d   = bypass_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d    = StSync;
          lfsr_d     = (seed == 32'h0) ? 32'h1 : seed;
          err_d      = 16'h0;
          first_d    = NoErr;
          pass_d     = 1'b0;
          cnt_d      = 16'h0;
          accum_in_d = 32'h0;
          bypass_d   = 1'b0;
        end
      end
      StSync: begin
        // The accumulator has no reset: adopt whatever it holds as the model's start point.
        state_d    = StRun;
        model_d    = eff_en ? accum_out + SECRET_VALUE : accum_out;
        err_d      = 16'h0;
        first_d    = NoErr;
        cnt_d      = 16'h0;
        accum_in_d = 32'h0;
        bypass_d   = 1'b0;
      end
      StRun: begin
        if (mismatch) begin
          if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
          if (first_q == NoErr) first_d = cnt_q;
        end
        if (eff_en) model_d = model_q + accum_in_q + SECRET_VALUE;
        lfsr_d     = lfsr_step;
        accum_in_d = lfsr_step;
        bypass_d   = lfsr_step[31];
        cnt_d      = cnt_q + 16'd1;
        if (cnt_q == LastCycle) begin
          state_d    = StDone;
          accum_in_d = 32'h0;
          bypass_d   = 1'b0;
          pass_d     = (err_d == 16'h0);
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d == StSync) || (state_d == StRun);
    done_d = (state_d == StDone);
  end

`ifdef SECRET_DRIVER_GATED_CLK_EN
  always_comb begin
    clk_en_d = 1'b1;
    if (state_q == StRun && state_d == StRun) clk_en_d = lfsr_step[0];
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      lfsr_q     <= 32'h1;
      model_q    <= 32'h0;
      cnt_q      <= 16'h0;
      err_q      <= 16'h0;
      first_q    <= NoErr;
      pass_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      accum_in_q <= 32'h0;
      bypass_q   <= 1'b0;
`ifdef SECRET_DRIVER_GATED_CLK_EN
      clk_en_q   <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      model_q    <= model_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      first_q    <= first_d;
      pass_q     <= pass_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      accum_in_q <= accum_in_d;
      bypass_q   <= bypass_d;
`ifdef SECRET_DRIVER_GATED_CLK_EN
      clk_en_q   <= clk_en_d;
`endif
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign err_count       = err_q;
  assign first_err_cycle = first_q;
  assign accum_in        = accum_in_q;
  assign accum_bypass    = bypass_q;

endmodule

// File: tb/tb_secret_driver.sv
// Scoreboard bench for secret_driver: a behavioural accumulator with fault/preload hooks;
// expected run results are queued at start and checked when done rises.
module tb_secret_driver;

  localparam logic [31:0] Secret = 32'd7;
  localparam int unsigned NCyc   = 256;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] seed = 32'h0;
  logic        busy, done, pass, accum_bypass, clk_en;
  logic [15:0] err_count, first_err_cycle;
  logic [31:0] accum_in, accum_out, accum_bypass_out;

  logic [31:0] acc = 32'h1234_5678;
  logic        flip = 1'b0;
  logic        preload = 1'b0;
  logic [31:0] preload_val = 32'h0;

  secret_driver #(.SECRET_VALUE(Secret), .NUM_CYCLES(NCyc), .LFSR_TAPS(32'h8020_0003)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .seed            (seed),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .err_count       (err_count),
    .first_err_cycle (first_err_cycle),
    .accum_in        (accum_in),
    .accum_bypass    (accum_bypass),
    .clk_en          (clk_en),
    .accum_out       (accum_out),
    .accum_bypass_out(accum_bypass_out)
  );

  always #5 clk = ~clk;

  // Reference accumulator: clk_en read at the edge is the value driven from the previous edge.
  always @(posedge clk) begin
    if (preload) acc <= preload_val;
    else if (clk_en) acc <= acc + accum_in + Secret;
  end
  assign accum_out        = acc ^ (flip ? 32'h20 : 32'h0);
  assign accum_bypass_out = accum_bypass ? accum_in : acc;

  typedef struct {
    logic        pass;
    logic [15:0] err;
    logic [15:0] first;
    int unsigned done_cyc;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          errors = 0;
  int          checks = 0;
  int          overlap = 0;
  int          en_low = 0;
  logic        done_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expectation per rising done.
  always @(negedge clk) begin
    exp_t e;
    if (done && !done_prev) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending run");
      end else begin
        e = sb.pop_front();
        check("pass", {31'h0, pass}, {31'h0, e.pass});
        check("err_count", {16'h0, err_count}, {16'h0, e.err});
        check("first_err_cycle", {16'h0, first_err_cycle}, {16'h0, e.first});
        check("done_cycle", cyc, e.done_cyc);
      end
    end
    done_prev <= done;
    if (busy && done) overlap <= overlap + 1;
    if (!clk_en) en_low <= en_low + 1;
  end

  task automatic issue(input logic [31:0] s, input bit push, input logic p,
                       input logic [15:0] e, input logic [15:0] f);
    exp_t x;
    @(negedge clk);
    seed  = s;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    x.pass     = p;
    x.err      = e;
    x.first    = f;
    x.done_cyc = cyc + NCyc + 1;
    if (push) sb.push_back(x);
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    while (!done && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got done=0 expected done=1 within %0d cycles", limit);
    end
    @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"}, {31'h0, busy}, 32'h0);
    check({tag, "_done"}, {31'h0, done}, 32'h0);
    check({tag, "_pass"}, {31'h0, pass}, 32'h0);
    check({tag, "_err"}, {16'h0, err_count}, 32'h0);
    check({tag, "_first"}, {16'h0, first_err_cycle}, 32'hFFFF);
    check({tag, "_accum_in"}, accum_in, 32'h0);
    check({tag, "_bypass"}, {31'h0, accum_bypass}, 32'h0);
    check({tag, "_clk_en"}, {31'h0, clk_en}, 32'h1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset_vals("por");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Clean run, seed 1.
    issue(32'h1, 1'b1, 1'b1, 16'h0, 16'hFFFF);
    wait_done(400);

    // Single-bit fault on the RUN edge with cycle index 40 (edge 42 after start).
    issue(32'hDEAD_BEEF, 1'b1, 1'b0, 16'd1, 16'd40);
    repeat (41) @(posedge clk);
    #1 flip = 1'b1;
    @(posedge clk);
    #1 flip = 1'b0;
    wait_done(400);

    // Accumulator near wrap before start; seed 0 maps to 1.
    @(negedge clk);
    preload_val = 32'hFFFF_FFF0;
    preload     = 1'b1;
    @(posedge clk);
    #1 preload = 1'b0;
    issue(32'h0, 1'b1, 1'b1, 16'h0, 16'hFFFF);
    wait_done(400);

    // Abort with reset at run cycle 100, then a fresh run must resync and pass.
    issue(32'h1357_9BDF, 1'b0, 1'b0, 16'h0, 16'h0);
    repeat (102) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check_reset_vals("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    issue(32'hA5A5_0001, 1'b1, 1'b1, 16'h0, 16'hFFFF);
    wait_done(400);

    // start pulsed mid-RUN is ignored; done timing unchanged.
    issue(32'h8000_0000, 1'b1, 1'b1, 16'h0, 16'hFFFF);
    repeat (11) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    check("midrun_busy", {31'h0, busy}, 32'h1);
    check("midrun_done", {31'h0, done}, 32'h0);
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(400);

    repeat (3) @(negedge clk);
    check("busy_done_overlap", overlap, 32'h0);
    check("scoreboard_empty", sb.size(), 32'h0);
`ifdef SECRET_DRIVER_GATED_CLK_EN
    check("clk_en_toggled", {31'h0, en_low > 0}, 32'h1);
`else
    check("clk_en_low_cycles", en_low, 32'h0);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before 2ms");
    $fatal(1, "watchdog");
  end

endmodule
